pupil_match_ctrl: RTL

- Sequences a template-matching pass of the 16x16-cell pupil template against one candidate origin in the frame buffer.
- Per template cell: drives cell-centre coordinates to the combinational template lookup (iX/iY -> oVAL), fetches the frame pixel at origin+offset over a req/valid handshake, and accumulates the sum of absolute differences (SAD).
- Tracks the best (lowest) SAD and its origin across successive candidates.
- Sits between the search-window scanner (issues iSTART per candidate) and the template lookup / frame-memory read port.

---
 rtl/pupil_match_ctrl.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pupil_match_ctrl.sv
// pupil_match_ctrl
// Sequences one template-matching pass of the TPL_DIM x TPL_DIM pupil template
// against a candidate origin in the frame buffer. For every template cell it
// presents the cell-centre coordinate to the combinational template lookup,
// fetches the frame pixel at origin+offset over a req/valid handshake, and
// accumulates the sum of absolute differences (SAD). The lowest SAD seen since
// reset (or since iCLR_BEST) is kept together with its origin.
//
// Optional feature (macro PUPIL_EARLY_ABORT_EN): a candidate stops as soon as
// its running SAD reaches the current best, reporting the partial SAD and
// pulsing oABORT together with oDONE. Undefined by default: every cell is
// always processed and oABORT does not exist.
module pupil_match_ctrl #(
  parameter int TPL_DIM = 16,
  parameter int HALVING = 3,
  parameter int PIX_W   = 10,
  parameter int SCORE_W = 18
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iSTART,
  input  logic [12:0]        iBASE_X,
  input  logic [12:0]        iBASE_Y,
  input  logic               iCLR_BEST,
  output logic [12:0]        oTPL_X,
  output logic [12:0]        oTPL_Y,
  input  logic [10:0]        iTPL_VAL,
  output logic               oPIX_REQ,
  output logic [12:0]        oPIX_X,
  output logic [12:0]        oPIX_Y,
  input  logic               iPIX_VALID,
  input  logic [PIX_W-1:0]   iPIX_VAL,
  output logic               oBUSY,
  output logic               oDONE,
  output logic [SCORE_W-1:0] oSCORE,
  output logic [SCORE_W-1:0] oBEST_SCORE,
  output logic [12:0]        oBEST_X,
`ifdef PUPIL_EARLY_ABORT_EN
  output logic               oABORT,
`endif
  output logic [12:0]        oBEST_Y
);

  localparam int COORD_W = 13;
  localparam int CELL_W  = $clog2(TPL_DIM);
  localparam int IDX_W   = 2 * CELL_W;
  localparam int CELLS   = TPL_DIM * TPL_DIM;

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(CELLS - 1);
  localparam logic [COORD_W-1:0] HALF_CELL = COORD_W'(1 << (HALVING - 1));

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ACC,
    ST_DONE
  } stateType;

  stateType state, nextState;

  // Candidate origin and cell walk.
  logic [COORD_W-1:0] baseX, baseY;
  logic [IDX_W-1:0]   cellIdx;

  // Operands and accumulator.
  logic [PIX_W-1:0]   tplQ, pixQ;
  logic [PIX_W-1:0]   absDiff;
  logic [SCORE_W-1:0] acc, accNext;

  // FSM strobes.
  logic startAccept;
  logic advance;
  logic finish;
  logic stopEarly;
  logic passAborted;

  // Next cell coordinates, shared by the start and advance paths.
  logic [IDX_W-1:0]   loadIdx;
  logic [COORD_W-1:0] selBaseX, selBaseY;
  logic [COORD_W-1:0] nextTplX, nextTplY;

  // The lookup result is one bit wider than the SAD operand; the top bit is dropped.
  logic unusedTplBits;
  assign unusedTplBits = ^iTPL_VAL[10:PIX_W];

  // Cell centre in template space: (c << HALVING) + half a cell.
  function automatic logic [COORD_W-1:0] cellCentre(input logic [CELL_W-1:0] c);
    return (COORD_W'(c) << HALVING) + HALF_CELL;
  endfunction

  // SAD step for the cell currently held in tplQ/pixQ.
  always_comb begin
    absDiff = (pixQ >= tplQ) ? (pixQ - tplQ) : (tplQ - pixQ);
    accNext = acc + SCORE_W'(absDiff);
  end

`ifdef PUPIL_EARLY_ABORT_EN
  assign stopEarly   = (accNext >= oBEST_SCORE);
  assign passAborted = oABORT;
`else
  assign stopEarly   = 1'b0;
  assign passAborted = 1'b0;
`endif

  // Coordinates for the cell about to be issued: cell 0 on start, k+1 on advance.
  always_comb begin
    loadIdx  = startAccept ? '0 : (cellIdx + IDX_W'(1));
    selBaseX = startAccept ? iBASE_X : baseX;
    selBaseY = startAccept ? iBASE_Y : baseY;
    nextTplX = cellCentre(loadIdx[CELL_W-1:0]);
    nextTplY = cellCentre(loadIdx[IDX_W-1:CELL_W]);
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // FSM next-state and control strobes.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    nextState   = state;
    startAccept = 1'b0;
    advance     = 1'b0;
    finish      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (iSTART) begin
          startAccept = 1'b1;
          nextState   = ST_ISSUE;
        end
      end
      ST_ISSUE: nextState = ST_WAIT;
      ST_WAIT: begin
        if (iPIX_VALID) begin
          nextState = ST_ACC;
        end
      end
      ST_ACC: begin
        if ((cellIdx == LAST_IDX) || stopEarly) begin
          finish    = 1'b1;
          nextState = ST_DONE;
        end else begin
          advance   = 1'b1;
          nextState = ST_ISSUE;
        end
      end
      ST_DONE: nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  // Origin latch, cell index and registered lookup / frame-read coordinates.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      baseX   <= '0;
      baseY   <= '0;
      cellIdx <= '0;
      oTPL_X  <= '0;
      oTPL_Y  <= '0;
      oPIX_X  <= '0;
      oPIX_Y  <= '0;
    end else if (startAccept || advance) begin
      if (startAccept) begin
        baseX <= iBASE_X;
        baseY <= iBASE_Y;
      end
      cellIdx <= loadIdx;
      oTPL_X  <= nextTplX;
      oTPL_Y  <= nextTplY;
      // Frame addresses wrap modulo 2^13 by construction of the width.
      oPIX_X  <= selBaseX + nextTplX;
      oPIX_Y  <= selBaseY + nextTplY;
    end
  end

  // Operand capture and SAD accumulation.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      tplQ <= '0;
      pixQ <= '0;
      acc  <= '0;
    end else begin
      if (state == ST_ISSUE) begin
        tplQ <= iTPL_VAL[PIX_W-1:0];
      end
      // Valid strobes outside WAIT belong to nobody and are dropped.
      if ((state == ST_WAIT) && iPIX_VALID) begin
        pixQ <= iPIX_VAL;
      end
      if (startAccept) begin
        acc <= '0;
      end else if (state == ST_ACC) begin
        acc <= accNext;
      end
    end
  end

  // Handshake, status and result outputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oPIX_REQ <= 1'b0;
      oBUSY    <= 1'b0;
      oDONE    <= 1'b0;
      oSCORE   <= '0;
    end else begin
      oPIX_REQ <= (nextState == ST_ISSUE);
      oBUSY    <= (nextState != ST_IDLE);
      oDONE    <= finish;
      if (finish) begin
        oSCORE <= accNext;
      end
    end
  end

`ifdef PUPIL_EARLY_ABORT_EN
  // Abort flag rides alongside oDONE for passes cut short by the best score.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oABORT <= 1'b0;
    end else begin
      oABORT <= finish && stopEarly;
    end
  end
`endif

  // Best-match record; a clear in the DONE cycle overrides the update.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oBEST_SCORE <= '1;
      oBEST_X     <= '0;
      oBEST_Y     <= '0;
    end else if (iCLR_BEST) begin
      oBEST_SCORE <= '1;
      oBEST_X     <= '0;
      oBEST_Y     <= '0;
    end else if ((state == ST_DONE) && !passAborted && (acc < oBEST_SCORE)) begin
      oBEST_SCORE <= acc;
      oBEST_X     <= baseX;
      oBEST_Y     <= baseY;
    end
  end

endmodule
